mem_slot_arbiter: RTL and testbench

MEM_SLOT_ARBITER -- requirements
Module: mem_slot_arbiter

---
 rtl/arb_pkg.sv | 27 ++
 rtl/slot_timer.sv | 29 ++
 rtl/mem_slot_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_slot_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared timing constants and phase encoding for the 16-slot memory arbiter frame.
// The optional Pi-steal behaviour (ARB_PI_STEAL_EN) lives in mem_slot_arbiter; nothing here depends on it.
package arb_pkg;

    typedef enum logic [1:0] {
        PHASE_PI   = 2'd0,
        PHASE_VRAM = 2'd1,
        PHASE_VROM = 2'd2,
        PHASE_CPU  = 2'd3
    } phase_e;

    localparam int SLOTS_PER_FRAME = 16;
    localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

    localparam logic [1:0] STROBE_FIRST = 2'd1;
    localparam logic [1:0] STROBE_LAST  = 2'd2;
    localparam logic [1:0] PHASE_END    = 2'd3;

    localparam logic [SLOT_W-1:0] CPU_SAMPLE_SLOT = SLOT_W'(11);
    localparam logic [SLOT_W-1:0] PI_SAMPLE_SLOT  = SLOT_W'(15);
    localparam logic [SLOT_W-1:0] LAST_SLOT       = SLOT_W'(SLOTS_PER_FRAME - 1);

    function automatic logic in_strobe_window(input logic [1:0] sub);
        return (sub >= STROBE_FIRST) && (sub <= STROBE_LAST);
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Free-running slot counter for the 1 MHz frame plus the phase and strobe-window decode.
module slot_timer
    import arb_pkg::*;
(
    input  logic              clk16,
    input  logic              rst_n,
    output logic [SLOT_W-1:0] slot,
    output logic [1:0]        phase,
    output logic              strobe_win,
    output logic              phase_end
);

    // NOTE: state is updated with non-blocking assignments only, and the reset
    // branch is asynchronous so the counter drops to 0 the moment rst_n falls.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (slot == LAST_SLOT) begin
            slot <= '0;
        end else begin
            slot <= slot + SLOT_W'(1);
        end
    end

    assign phase      = slot[SLOT_W-1 -: 2];
    assign strobe_win = in_strobe_window(slot[1:0]);
    assign phase_end  = (slot[1:0] == PHASE_END);

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-slot bus arbiter: Pi / video RAM / character ROM / CPU phases in a fixed 16-cycle frame.
// Optional macro ARB_PI_STEAL_EN lets a pending Pi request take a CPU phase the CPU gave up.
module mem_slot_arbiter
    import arb_pkg::*;
(
    input  logic       clk16_i,
    input  logic       reset_n_i,
    input  logic       cpu_en_i,
    input  logic       pi_req_i,
    output logic       pi_select_o,
    output logic       pi_strobe_o,
    output logic       video_select_o,
    output logic       video_ram_strobe_o,
    output logic       video_rom_strobe_o,
    output logic       cpu_select_o,
    output logic       cpu_strobe_o,
    output logic       pi_done_o,
    output logic [3:0] slot_o
);

    logic [SLOT_W-1:0] slot;
    logic [1:0]        phase_raw;
    phase_e            phase;
    logic              strobe_win;
    logic              phase_end;

    logic pi_pend;
    logic cpu_grant;
`ifdef ARB_PI_STEAL_EN
    logic pi_steal;
`endif

    slot_timer u_slot_timer (
        .clk16      (clk16_i),
        .rst_n      (reset_n_i),
        .slot       (slot),
        .phase      (phase_raw),
        .strobe_win (strobe_win),
        .phase_end  (phase_end)
    );

    assign phase  = phase_e'(phase_raw);
    assign slot_o = slot;

    // Grants are sampled once per frame so a mid-phase input change never
    // produces a truncated or partial phase.
    always_ff @(posedge clk16_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pi_pend   <= 1'b0;
            cpu_grant <= 1'b0;
        end else begin
            if (slot == PI_SAMPLE_SLOT) begin
                pi_pend <= pi_req_i;
            end else if (phase == PHASE_PI && phase_end) begin
                pi_pend <= 1'b0;
            end
            if (slot == CPU_SAMPLE_SLOT) begin
                cpu_grant <= cpu_en_i;
            end
        end
    end

`ifdef ARB_PI_STEAL_EN
    // A halted CPU's phase goes to the Pi; its done pulse lands on slot 15,
    // the same edge that samples the request for the next PI phase.
    always_ff @(posedge clk16_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pi_steal <= 1'b0;
        end else if (slot == CPU_SAMPLE_SLOT) begin
            pi_steal <= !cpu_en_i && pi_req_i;
        end else if (slot == PI_SAMPLE_SLOT) begin
            pi_steal <= 1'b0;
        end
    end
`endif

    // NOTE: every output gets a default before the case, so no path through
    // this block can leave a signal unassigned and infer a latch.
    always_comb begin
        pi_select_o        = 1'b0;
        pi_strobe_o        = 1'b0;
        pi_done_o          = 1'b0;
        video_select_o     = 1'b0;
        video_ram_strobe_o = 1'b0;
        video_rom_strobe_o = 1'b0;
        cpu_select_o       = 1'b0;
        cpu_strobe_o       = 1'b0;
        unique case (phase)
            PHASE_PI: begin
                if (pi_pend) begin
                    pi_select_o = 1'b1;
                    pi_strobe_o = strobe_win;
                    pi_done_o   = phase_end;
                end
            end
            PHASE_VRAM: begin
                video_select_o     = 1'b1;
                video_ram_strobe_o = strobe_win;
            end
            PHASE_VROM: begin
                video_select_o     = 1'b1;
                video_rom_strobe_o = strobe_win;
            end
            PHASE_CPU: begin
                if (cpu_grant) begin
                    cpu_select_o = 1'b1;
                    cpu_strobe_o = strobe_win;
                end
`ifdef ARB_PI_STEAL_EN
                else if (pi_steal) begin
                    pi_select_o = 1'b1;
                    pi_strobe_o = strobe_win;
                    pi_done_o   = phase_end;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter: per-frame output masks compared against hand-computed slot patterns.
`timescale 1ns/1ps
module tb_mem_slot_arbiter;

`ifdef ARB_PI_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] pi_sel;
        logic [15:0] pi_stb;
        logic [15:0] pi_done;
        logic [15:0] vid_sel;
        logic [15:0] vram_stb;
        logic [15:0] vrom_stb;
        logic [15:0] cpu_sel;
        logic [15:0] cpu_stb;
    } frame_t;

    logic       clk16;
    logic       reset_n;
    logic       cpu_en;
    logic       pi_req;
    logic       pi_select, pi_strobe, video_select, video_ram_strobe, video_rom_strobe;
    logic       cpu_select, cpu_strobe, pi_done;
    logic [3:0] slot;

    int tests_run;
    int tests_failed;
    int sel_violations;

    mem_slot_arbiter dut (
        .clk16_i            (clk16),
        .reset_n_i          (reset_n),
        .cpu_en_i           (cpu_en),
        .pi_req_i           (pi_req),
        .pi_select_o        (pi_select),
        .pi_strobe_o        (pi_strobe),
        .video_select_o     (video_select),
        .video_ram_strobe_o (video_ram_strobe),
        .video_rom_strobe_o (video_rom_strobe),
        .cpu_select_o       (cpu_select),
        .cpu_strobe_o       (cpu_strobe),
        .pi_done_o          (pi_done),
        .slot_o             (slot)
    );

    initial begin
        clk16 = 1'b0;
        forever #31 clk16 = ~clk16;
    end

    // At most one select per cycle, and no strobe or done without its select.
    always @(negedge clk16) begin
        if (($countones({pi_select, video_select, cpu_select}) > 1) ||
            (pi_strobe && !pi_select) || (pi_done && !pi_select) ||
            ((video_ram_strobe || video_rom_strobe) && !video_select) ||
            (cpu_strobe && !cpu_select)) begin
            sel_violations = sel_violations + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] all_outs();
        return {pi_select, pi_strobe, pi_done, video_select,
                video_ram_strobe, video_rom_strobe, cpu_select, cpu_strobe};
    endfunction

    task automatic wait_slot(input logic [3:0] s);
        int n;
        n = 0;
        while (slot !== s && n < 40) begin
            @(negedge clk16);
            n++;
        end
        if (slot !== s) check("wait_slot_timeout", 32'(slot), 32'(s));
    endtask

    // Records one full frame starting at slot 0; optional mid-frame input drops.
    task automatic run_frame(input int req_drop, input int cpu_drop, output frame_t f);
        f = '0;
        wait_slot(4'd0);
        for (int i = 0; i < 16; i++) begin
            f.pi_sel[i]   = pi_select;
            f.pi_stb[i]   = pi_strobe;
            f.pi_done[i]  = pi_done;
            f.vid_sel[i]  = video_select;
            f.vram_stb[i] = video_ram_strobe;
            f.vrom_stb[i] = video_rom_strobe;
            f.cpu_sel[i]  = cpu_select;
            f.cpu_stb[i]  = cpu_strobe;
            if (i == req_drop) pi_req = 1'b0;
            if (i == cpu_drop) cpu_en = 1'b0;
            @(negedge clk16);
        end
    endtask

    initial begin
        frame_t f;
        int     pulses;
        logic   seen;

        tests_run      = 0;
        tests_failed   = 0;
        sel_violations = 0;
        reset_n        = 1'b0;
        cpu_en         = 1'b1;
        pi_req         = 1'b0;

        // Reset state and first post-reset edge
        repeat (3) @(negedge clk16);
        check("reset_outs", 32'(all_outs()), 32'h0);
        check("reset_slot", 32'(slot), 32'h0);
        reset_n = 1'b1;
        @(negedge clk16);
        check("first_edge_slot", 32'(slot), 32'h1);

        // Two idle-Pi frames with the CPU running
        for (int fr = 0; fr < 2; fr++) begin
            run_frame(-1, -1, f);
            check("idle_vram_stb", 32'(f.vram_stb), 32'h0060);
            check("idle_vrom_stb", 32'(f.vrom_stb), 32'h0600);
            check("idle_vid_sel",  32'(f.vid_sel),  32'h0FF0);
            check("idle_cpu_stb",  32'(f.cpu_stb),  32'h6000);
            check("idle_cpu_sel",  32'(f.cpu_sel),  32'hF000);
            check("idle_pi_sel",   32'(f.pi_sel),   32'h0000);
        end

        // Held request: first frame only samples, then one access per frame
        pi_req = 1'b1;
        run_frame(-1, -1, f);
        check("req_sample_frame_pi_sel", 32'(f.pi_sel), 32'h0000);
        pulses = 0;
        for (int fr = 0; fr < 3; fr++) begin
            run_frame(-1, -1, f);
            check("grant_pi_sel",  32'(f.pi_sel),  32'h000F);
            check("grant_pi_stb",  32'(f.pi_stb),  32'h0006);
            check("grant_pi_done", 32'(f.pi_done), 32'h0008);
            pulses += $countones(f.pi_done);
        end
        check("grant_total_pulses", 32'(pulses), 32'd3);

        // Request dropped at slot 1 of a grant: access still completes
        run_frame(1, -1, f);
        check("drop_pi_stb",  32'(f.pi_stb),  32'h0006);
        check("drop_pi_done", 32'(f.pi_done), 32'h0008);
        run_frame(-1, -1, f);
        check("after_drop_pi_sel", 32'(f.pi_sel), 32'h0000);

        // CPU disabled at slot 12: current phase completes, next one idle
        run_frame(-1, 12, f);
        check("cpu_off_cur_sel", 32'(f.cpu_sel), 32'hF000);
        check("cpu_off_cur_stb", 32'(f.cpu_stb), 32'h6000);
        run_frame(-1, -1, f);
        check("cpu_off_next_sel", 32'(f.cpu_sel), 32'h0000);
        check("cpu_off_next_stb", 32'(f.cpu_stb), 32'h0000);
        check("cpu_off_next_pi",  32'(f.pi_sel),  32'h0000);

        // CPU halted with Pi request held: steal behaviour depends on the build
        pi_req = 1'b1;
        run_frame(-1, -1, f);
        check("steal_first_done", 32'(f.pi_done), STEAL ? 32'h8000 : 32'h0000);
        for (int fr = 0; fr < 2; fr++) begin
            run_frame(-1, -1, f);
            check("steal_pi_done", 32'(f.pi_done), STEAL ? 32'h8008 : 32'h0008);
            check("steal_pi_sel",  32'(f.pi_sel),  STEAL ? 32'hF00F : 32'h000F);
            check("steal_pi_stb",  32'(f.pi_stb),  STEAL ? 32'h6006 : 32'h0006);
            check("steal_cpu_sel", 32'(f.cpu_sel), 32'h0000);
        end

        // Reset pulsed at slot 2 of a Pi grant
        cpu_en = 1'b1;
        wait_slot(4'd2);
        check("pre_reset_pi_sel", 32'(pi_select), 32'h1);
        reset_n = 1'b0;
        #3;
        check("async_reset_outs", 32'(all_outs()), 32'h0);
        check("async_reset_slot", 32'(slot), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk16);
            #1 seen = seen | pi_done | pi_select;
            @(negedge clk16);
            seen = seen | pi_done | pi_select;
        end
        check("reset_no_done", 32'(seen), 32'h0);
        check("reset_hold_slot", 32'(slot), 32'h0);
        reset_n = 1'b1;
        @(negedge clk16);
        check("rerelease_slot", 32'(slot), 32'h1);
        seen = 1'b0;
        for (int i = 1; i < 16; i++) begin
            seen = seen | pi_select | pi_done;
            @(negedge clk16);
        end
        check("first_frame_no_grant", 32'(seen), 32'h0);
        check("recover_grant_slot", 32'(slot), 32'h0);
        check("recover_grant_sel", 32'(pi_select), 32'h1);

        check("select_exclusive", 32'(sel_violations), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
